dmem_sb: RTL and testbench

Data-memory responder for the five-stage RISC-V core's MEM stage. It serves the datapath's data port: address `ALUResultM`, store data `BM`, load data returned on `ReadDataM`. Stores go into a small in-order store buffer that drains into a single-port byte-enabled array whenever the port is idle. Loads are answered combinationally in the same cycle. A load that hits a pending store, or a store that finds the buffer full, raises a stall to the hazard unit.

---
 rtl/dmem_sb.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dmem_sb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sb.sv
// -----------------------------------------------------------------------------
// dmem_sb -- data-memory responder for the MEM stage of the five-stage core.
//
// Loads are answered combinationally from a single-port, byte-enabled word
// array. Stores are either written straight into the array, or parked in a
// small in-order store buffer that drains into the array whenever the port
// is not needed by a load.
//
// Configuration macro: DMEM_SB_STORE_BUFFER_EN
//   defined   : stores go through the SB_DEPTH-entry store buffer; a load that
//               hits a pending store, or a store that finds the buffer full,
//               raises StallM.
//   undefined : no buffer; stores write the array at the edge of their own
//               cycle, StallM is tied to 0 and SbEmpty to 1.
//
// Parameters
//   AW         word-address width, array holds 2^AW 32-bit words
//   SB_DEPTH   store-buffer entries (power of two, >= 2)
//
// Ports
//   clk         core clock, all state updates on the rising edge
//   rst         synchronous reset, active-high
//   MemReadM    load request this cycle
//   MemWriteM   store request this cycle (wins over a simultaneous load)
//   funct3M     access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALUResultM  byte address; bits above AW+1 are ignored (addresses wrap)
//   BM          store data, right-aligned
//   ReadDataM   load data, combinational
//   StallM      hold IF/ID/EX/MEM this cycle, combinational
//   MisalignM   misaligned access flag, combinational
//   SbEmpty     store buffer empty (for fence)
// -----------------------------------------------------------------------------
module dmem_sb #(
    parameter int AW       = 10,
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] BM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        SbEmpty
);

    localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W
    } size_e;

    logic [31:0]   r_mem [0:(1<<AW)-1];

    logic [AW-1:0] w_index;
    logic [1:0]    w_lane;
    size_e         w_loadSize;
    size_e         w_storeSize;
    size_e         w_accSize;
    logic          w_badAlign;
    logic          w_misalign;
    logic          w_storeOk;
    logic          w_loadOk;
    logic          w_loadHit;
    logic [3:0]    w_storeBe;
    logic [31:0]   w_storeData;
    logic [31:0]   w_rawWord;
    logic [31:0]   w_shifted;
    logic [31:0]   w_loadData;
    logic          w_memWe;
    logic [AW-1:0] w_memIdx;
    logic [3:0]    w_memBe;
    logic [31:0]   w_memData;
    logic          w_unused;

    assign w_index  = ALUResultM[AW+1:2];
    assign w_lane   = ALUResultM[1:0];
    assign w_unused = ^ALUResultM[31:AW+2];

    // Access size decode. Loads only look at funct3[1:0] (bit 2 is the
    // unsigned flag); stores treat every code other than B/H as a word.
    // When both requests are present the store owns the port, so its size
    // decides the misalignment flag.
    always_comb begin
        w_loadSize = SIZE_W;
        case (funct3M[1:0])
            2'b00:   w_loadSize = SIZE_B;
            2'b01:   w_loadSize = SIZE_H;
            default: w_loadSize = SIZE_W;
        endcase

        w_storeSize = SIZE_W;
        case (funct3M)
            3'b000:  w_storeSize = SIZE_B;
            3'b001:  w_storeSize = SIZE_H;
            default: w_storeSize = SIZE_W;
        endcase

        w_accSize = MemWriteM ? w_storeSize : w_loadSize;

        w_badAlign = 1'b0;
        case (w_accSize)
            SIZE_H:  w_badAlign = w_lane[0];
            SIZE_W:  w_badAlign = (w_lane != 2'b00);
            default: w_badAlign = 1'b0;
        endcase
    end

    assign w_misalign = (MemReadM | MemWriteM) & w_badAlign;
    assign MisalignM  = w_misalign;

    assign w_storeOk = MemWriteM & ~w_misalign;
    assign w_loadOk  = MemReadM & ~MemWriteM & ~w_misalign;

    // Store data is replicated across lanes so the byte enables alone pick
    // which bytes land in the array.
    always_comb begin
        w_storeBe   = 4'b1111;
        w_storeData = BM;
        case (w_storeSize)
            SIZE_B: begin
                w_storeBe   = 4'b0001 << w_lane;
                w_storeData = {4{BM[7:0]}};
            end
            SIZE_H: begin
                w_storeBe   = 4'b0011 << w_lane;
                w_storeData = {2{BM[15:0]}};
            end
            default: begin
                w_storeBe   = 4'b1111;
                w_storeData = BM;
            end
        endcase
    end

    // Lane selection and sign/zero extension of the addressed word.
    assign w_rawWord = r_mem[w_index];
    assign w_shifted = w_rawWord >> {w_lane, 3'b000};

    always_comb begin
        w_loadData = w_rawWord;
        case (w_loadSize)
            SIZE_B:  w_loadData = funct3M[2] ? {24'b0, w_shifted[7:0]}
                                             : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SIZE_H:  w_loadData = funct3M[2] ? {16'b0, w_shifted[15:0]}
                                             : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_loadData = w_rawWord;
        endcase
    end

    // A hitting load gets zero; the core re-presents it once the matching
    // entries have drained.
    assign ReadDataM = (w_loadOk && !w_loadHit) ? w_loadData : 32'b0;

`ifdef DMEM_SB_STORE_BUFFER_EN

    logic [AW-1:0] r_sbIdx  [0:SB_DEPTH-1];
    logic [3:0]    r_sbBe   [0:SB_DEPTH-1];
    logic [31:0]   r_sbData [0:SB_DEPTH-1];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic          w_full;
    logic          w_storeStall;
    logic          w_push;
    logic          w_pop;

    // A slot is live when its distance from the head is below the count;
    // any live slot with the same word index blocks the load, whatever
    // its byte enables, since there is no forwarding path.
    always_comb begin
        w_loadHit = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (w_loadOk && ({1'b0, PW'(i) - r_head} < r_count) &&
                (r_sbIdx[i] == w_index)) begin
                w_loadHit = 1'b1;
            end
        end
    end

    // Fullness uses the current count, so a full buffer stalls a store even
    // in a cycle where the head drains. The port goes to the buffer whenever
    // no load needs it, or the load is waiting on the buffer anyway.
    assign w_full       = (r_count == (PW+1)'(SB_DEPTH));
    assign w_storeStall = w_storeOk & w_full;
    assign w_push       = w_storeOk & ~w_full;
    assign w_pop        = (r_count != '0) & (~MemReadM | w_loadHit);

    assign StallM  = w_loadHit | w_storeStall;
    assign SbEmpty = (r_count == '0);

    // Head write is suppressed on a reset edge so discarded stores never
    // reach the array.
    assign w_memWe   = w_pop & ~rst;
    assign w_memIdx  = r_sbIdx[r_head];
    assign w_memBe   = r_sbBe[r_head];
    assign w_memData = r_sbData[r_head];

    // Circular pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload needs no reset; the pointers decide what is live.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_sbIdx[r_tail]  <= w_index;
            r_sbBe[r_tail]   <= w_storeBe;
            r_sbData[r_tail] <= w_storeData;
        end
    end

`else

    assign w_loadHit = 1'b0;
    assign StallM    = 1'b0;
    assign SbEmpty   = 1'b1;

    assign w_memWe   = w_storeOk & ~rst;
    assign w_memIdx  = w_index;
    assign w_memBe   = w_storeBe;
    assign w_memData = w_storeData;

`endif

    // Single write port into the array with per-byte enables. Contents are
    // deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (w_memBe[b]) begin
                    r_mem[w_memIdx][8*b +: 8] <= w_memData[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_sb.sv
// -----------------------------------------------------------------------------
// tb_dmem_sb -- self-checking bench for dmem_sb.
//
// The reference model keeps memory as a flat byte array and the store buffer
// as a queue of {byte address, size, value} records. Each stimulus cycle
// pushes the expected outputs into a scoreboard queue; an independent
// monitor pops and compares on the falling edge.
// Follows the DMEM_SB_STORE_BUFFER_EN macro the same way the design does.
// -----------------------------------------------------------------------------
module tb_dmem_sb;

    localparam int AW       = 10;
    localparam int SB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] BM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        SbEmpty;

    dmem_sb #(
        .AW       (AW),
        .SB_DEPTH (SB_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .BM         (BM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .SbEmpty    (SbEmpty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned byteAddr;
        int          size;
        logic [31:0] value;
    } pending_t;

    typedef struct {
        logic [31:0] rd;
        logic        stall;
        logic        mis;
        logic        empty;
        int unsigned cyc;
    } expect_t;

    pending_t    modelSb[$];
    expect_t     expQ[$];
    logic [7:0]  modelMem [0:(4<<AW)-1];
    int unsigned checks  = 0;
    int unsigned passes  = 0;
    int unsigned cycleNo = 0;

    function automatic int accessSize(input logic isStore, input logic [2:0] f3);
        if (isStore) begin
            if (f3 == 3'b000) return 1;
            if (f3 == 3'b001) return 2;
            return 4;
        end
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int unsigned wrapByte(input logic [31:0] addr);
        return addr & ((32'd4 << AW) - 32'd1);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [2:0] f3);
        int unsigned base;
        int          sz;
        logic [31:0] v;
        sz   = accessSize(1'b0, f3);
        base = wrapByte(addr);
        v    = 32'd0;
        for (int k = 0; k < sz; k++) v = v | (32'(modelMem[base + k]) << (8 * k));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        return v;
    endfunction

    task automatic modelWrite(input pending_t p);
        for (int k = 0; k < p.size; k++) modelMem[p.byteAddr + k] = p.value[8*k +: 8];
    endtask

    // One cycle: drive inputs, predict outputs, advance the model at the edge.
    task automatic applyStimulus(input logic re, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] bm,
                                 output logic stallExp);
        expect_t  e;
        pending_t p;
        int       sz;
        logic     mis;
        logic     hit;
        logic     push;
        logic     pop;
        MemReadM   = re;
        MemWriteM  = we;
        funct3M    = f3;
        ALUResultM = addr;
        BM         = bm;
        sz  = accessSize(we, f3);
        mis = (re || we) && ((addr % sz) != 0);
        hit = 1'b0;
        p.byteAddr = wrapByte(addr);
        p.size     = sz;
        p.value    = bm;
        push = we && !mis;
        pop  = 1'b0;
        e.stall = 1'b0;
        e.empty = 1'b1;
`ifdef DMEM_SB_STORE_BUFFER_EN
        if (re && !we && !mis)
            foreach (modelSb[i]) if ((modelSb[i].byteAddr >> 2) == (p.byteAddr >> 2)) hit = 1'b1;
        if (push && modelSb.size() == SB_DEPTH) begin
            push    = 1'b0;
            e.stall = 1'b1;
        end
        if (hit) e.stall = 1'b1;
        pop     = (modelSb.size() > 0) && (!re || hit);
        e.empty = (modelSb.size() == 0);
`endif
        e.mis = mis;
        e.rd  = (re && !we && !mis && !hit) ? modelLoad(addr, f3) : 32'd0;
        e.cyc = cycleNo;
        expQ.push_back(e);
        stallExp = e.stall;
        @(posedge clk);
`ifdef DMEM_SB_STORE_BUFFER_EN
        if (pop) begin
            modelWrite(modelSb[0]);
            void'(modelSb.pop_front());
        end
        if (push) modelSb.push_back(p);
`else
        if (push) modelWrite(p);
`endif
        #1;
        cycleNo++;
    endtask

    // Issue a request and keep re-presenting it while it stalls, the way the
    // core would. A combined load+store that stalls drops its load on retry.
    task automatic issue(input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] bm);
        logic s;
        logic r;
        int   tries;
        r     = re;
        tries = 0;
        applyStimulus(r, we, f3, addr, bm, s);
        while (s && tries < 10) begin
            if (r && we) r = 1'b0;
            applyStimulus(r, we, f3, addr, bm, s);
            tries++;
        end
        if (s) begin
            checks++;
            $display("[TB] FAIL stall-bound cycle %0d: still stalled after %0d retries, required release", cycleNo, tries);
        end
    endtask

    task automatic idle();
        logic s;
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, s);
    endtask

    task automatic doReset();
        rst        = 1'b1;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        funct3M    = 3'b000;
        ALUResultM = 32'd0;
        BM         = 32'd0;
        @(posedge clk);
        modelSb.delete();
        #1;
        rst = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp, input int unsigned cyc);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s cycle %0d: got %h, required %h", name, cyc, act, exp);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest prediction.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("ReadDataM", ReadDataM, e.rd, e.cyc);
                checkOutput("StallM", {31'd0, StallM}, {31'd0, e.stall}, e.cyc);
                checkOutput("MisalignM", {31'd0, MisalignM}, {31'd0, e.mis}, e.cyc);
                checkOutput("SbEmpty", {31'd0, SbEmpty}, {31'd0, e.empty}, e.cyc);
            end
        end
    end

    initial begin
        int          sel;
        int          drainTries;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  loadCodes [0:4];
        loadCodes[0] = 3'b000;
        loadCodes[1] = 3'b001;
        loadCodes[2] = 3'b010;
        loadCodes[3] = 3'b100;
        loadCodes[4] = 3'b101;
        for (int i = 0; i < (4 << AW); i++) modelMem[i] = 8'h00;

        doReset();
        idle();

        // Give every word the bench touches a defined value.
        for (int w = 0; w < 16; w++) issue(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom);
        repeat (2) idle();

        // Directed scenarios.
        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        idle();
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'd0);
        issue(1'b0, 1'b1, 3'b000, 32'h13, 32'h80);
        repeat (2) idle();
        issue(1'b1, 1'b0, 3'b000, 32'h13, 32'd0);
        issue(1'b1, 1'b0, 3'b100, 32'h13, 32'd0);
        issue(1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678);
        issue(1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
        issue(1'b1, 1'b0, 3'b001, 32'h21, 32'd0);
        issue(1'b0, 1'b1, 3'b010, 32'h22, 32'hCAFEF00D);
        idle();
        issue(1'b1, 1'b0, 3'b010, 32'h20, 32'd0);
        issue(1'b1, 1'b0, 3'b010, 32'h1000_0010, 32'd0);
        for (int k = 0; k < 5; k++) issue(1'b1, 1'b1, 3'b010, 32'(32'h24 + 4 * k), $urandom);
        repeat (6) idle();
        issue(1'b1, 1'b1, 3'b010, 32'h30, 32'h11111111);
        issue(1'b1, 1'b1, 3'b010, 32'h34, 32'h22222222);
        doReset();
        idle();
        issue(1'b1, 1'b0, 3'b010, 32'h30, 32'd0);
        issue(1'b1, 1'b0, 3'b010, 32'h34, 32'd0);

        // Randomised traffic over 16 words with random aliasing high bits.
        for (int n = 0; n < 1500; n++) begin
            sel  = $urandom_range(0, 9);
            addr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) |
                   32'($urandom_range(0, 3));
            if (sel <= 3) begin
                f3 = loadCodes[$urandom_range(0, 4)];
                issue(1'b1, 1'b0, f3, addr, 32'd0);
            end else if (sel <= 7) begin
                f3 = 3'($urandom_range(0, 7));
                issue(1'b0, 1'b1, f3, addr, $urandom);
            end else if (sel == 8) begin
                issue(1'b1, 1'b1, 3'b010, addr & 32'hFFFF_FFFC, $urandom);
            end else begin
                idle();
            end
        end

        drainTries = 0;
        while (modelSb.size() > 0 && drainTries < 20) begin
            idle();
            drainTries++;
        end
        idle();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
